// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, init tables and default timing for the 4-bit LCD write controller.
// Contents: lcd_state_t (controller FSM), tx_phase_t (nibble strobe FSM), *_DEF timing
// constants in CLK cycles, init nibble/command tables and small helper functions.
package lcd_pkg;

    typedef enum logic [2:0] {PWRUP, INIT_NIB, INIT_CMD, IDLE, NIB_HI, GAP, NIB_LO, WAIT} lcd_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SU, TX_EH} tx_phase_t;

    localparam int T_PWRUP_DEF   = 750000;
    localparam int T_SU_DEF      = 2;
    localparam int T_E_DEF       = 12;
    localparam int T_GAP_DEF     = 50;
    localparam int T_CMD_DEF     = 2000;
    localparam int T_CLR_DEF     = 82000;
    localparam int T_INIT_W0_DEF = 205000;
    localparam int T_INIT_W1_DEF = 5000;
    localparam int T_INIT_W2_DEF = 2000;
    localparam int T_INIT_W3_DEF = 2000;

    // Entry i lives at bits [4i+:4] / [8i+:8]: nibbles 3,3,3,2 then bytes 28,06,0C,01.
    localparam logic [15:0] INIT_NIBS = 16'h2333;
    localparam logic [31:0] INIT_CMDS = 32'h010C_0628;

    function automatic logic [3:0] init_nib(input logic [1:0] i);
        return INIT_NIBS[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        return INIT_CMDS[{i, 3'b000} +: 8];
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    function automatic logic is_clr(input logic rs, input logic [7:0] d);
        return !rs && d[7:2] == 6'd0;
    endfunction

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: drives one nibble onto the LCD bus with setup, strobe width and hold timing.
// Ports: CLK, RST_N (async, active-low); start (load nib/rs this edge), nib, rs;
// db (DB7..DB4), lcd_rs, lcd_e; done (high the cycle before the edge on which lcd_e falls).
// Pins stay put after the strobe until the next start, which gives the required hold.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int T_SU = T_SU_DEF,
    parameter int T_E  = T_E_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [3:0] nib,
    input  logic       rs,
    output logic [3:0] db,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic       done
);

    localparam int NW = $clog2(max2(T_SU, T_E) + 1);

    tx_phase_t     ph;
    logic [NW-1:0] cnt;

    assign done = ph == TX_EH && cnt == '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ph     <= TX_IDLE;
            cnt    <= '0;
            db     <= '0;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
        end else if (start) begin
            db     <= nib;
            lcd_rs <= rs;
            lcd_e  <= 1'b0;
            ph     <= TX_SU;
            cnt    <= NW'(T_SU - 1);
        end else begin
            case (ph)
                TX_SU: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        ph    <= TX_EH;
                        cnt   <= NW'(T_E - 1);
                    end else begin
                        cnt <= cnt - NW'(1);
                    end
                end
                TX_EH: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        ph    <= TX_IDLE;
                    end else begin
                        cnt <= cnt - NW'(1);
                    end
                end
                default: ph <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: write-only 4-bit HD44780-style LCD controller with a byte request handshake.
// Ports: CLK, RST_N (async, active-low); REQ_VALID/REQ_RS/REQ_DATA/REQ_READY request side;
// INIT_DONE; LCD_E, LCD_RS, LCD_RW (tied 0), SF_E (tied 1), SF_D..SF_A = DB7..DB4.
// Macro LCD_INIT_SEQ_EN: when defined, runs the power-up wait and init sequence after reset;
// otherwise the controller is ready on the first clock after reset release.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP   = T_PWRUP_DEF,
    parameter int T_SU      = T_SU_DEF,
    parameter int T_E       = T_E_DEF,
    parameter int T_GAP     = T_GAP_DEF,
    parameter int T_CMD     = T_CMD_DEF,
    parameter int T_CLR     = T_CLR_DEF,
    parameter int T_INIT_W0 = T_INIT_W0_DEF,
    parameter int T_INIT_W1 = T_INIT_W1_DEF,
    parameter int T_INIT_W2 = T_INIT_W2_DEF,
    parameter int T_INIT_W3 = T_INIT_W3_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ_VALID,
    input  logic       REQ_RS,
    input  logic [7:0] REQ_DATA,
    output logic       REQ_READY,
    output logic       INIT_DONE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       SF_E,
    output logic       SF_D,
    output logic       SF_C,
    output logic       SF_B,
    output logic       SF_A
);

    // One shared wait counter, wide enough for the longest wait of any kind.
    localparam int CW = $clog2(max2(max2(max2(T_PWRUP, T_CLR), max2(T_CMD, T_GAP)),
                                    max2(max2(T_INIT_W0, T_INIT_W1), max2(T_INIT_W2, T_INIT_W3))) + 1);

    lcd_state_t    state;
    logic [CW-1:0] cnt;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          tx_start;
    logic          tx_rs;
    logic          tx_done;
    logic [3:0]    tx_nib;
    logic [3:0]    db;

`ifdef LCD_INIT_SEQ_EN
    // idx 0..3 walks the init nibbles, 4..7 the init commands; it wraps to 0 after the last one.
    logic [2:0] idx;
    logic [7:0] cmd_byte;

    function automatic logic [CW-1:0] init_wait(input logic [1:0] i);
        return i == 2'd0 ? CW'(T_INIT_W0 - 1) :
               i == 2'd1 ? CW'(T_INIT_W1 - 1) :
               i == 2'd2 ? CW'(T_INIT_W2 - 1) : CW'(T_INIT_W3 - 1);
    endfunction

    assign cmd_byte = init_cmd(idx[1:0]);
`endif

    assign LCD_RW = 1'b0;
    assign SF_E   = 1'b1;
    assign {SF_D, SF_C, SF_B, SF_A} = db;

    // Starts fire on the edge that enters a sending state, so pins change on that same edge.
    always_comb begin
        tx_start = 1'b0;
        tx_nib   = data_q[3:0];
        tx_rs    = rs_q;
        if (state == IDLE && REQ_VALID && REQ_READY) begin
            tx_start = 1'b1;
            tx_nib   = REQ_DATA[7:4];
            tx_rs    = REQ_RS;
        end else if (state == GAP && cnt == '0) begin
            tx_start = 1'b1;
`ifdef LCD_INIT_SEQ_EN
        end else if (state == INIT_CMD) begin
            tx_start = 1'b1;
            tx_nib   = cmd_byte[7:4];
            tx_rs    = 1'b0;
        end else if (state == PWRUP && cnt == CW'(T_PWRUP - 1)) begin
            tx_start = 1'b1;
            tx_nib   = init_nib(2'd0);
            tx_rs    = 1'b0;
        end else if (state == WAIT && cnt == '0 && !INIT_DONE && idx != 3'd0 && !idx[2]) begin
            tx_start = 1'b1;
            tx_nib   = init_nib(idx[1:0]);
            tx_rs    = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= PWRUP;
            cnt       <= '0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            REQ_READY <= 1'b0;
            INIT_DONE <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            idx       <= '0;
`endif
        end else begin
            case (state)
                PWRUP: begin
`ifdef LCD_INIT_SEQ_EN
                    if (cnt == CW'(T_PWRUP - 1)) begin
                        state <= INIT_NIB;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
`else
                    state     <= IDLE;
                    REQ_READY <= 1'b1;
                    INIT_DONE <= 1'b1;
`endif
                end
`ifdef LCD_INIT_SEQ_EN
                INIT_NIB: begin
                    if (tx_done) begin
                        state <= WAIT;
                        cnt   <= init_wait(idx[1:0]);
                        idx   <= idx + 3'd1;
                    end
                end
                INIT_CMD: begin
                    data_q <= cmd_byte;
                    rs_q   <= 1'b0;
                    idx    <= idx + 3'd1;
                    state  <= NIB_HI;
                end
`endif
                IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        data_q    <= REQ_DATA;
                        rs_q      <= REQ_RS;
                        REQ_READY <= 1'b0;
                        state     <= NIB_HI;
                    end
                end
                NIB_HI: begin
                    if (tx_done) begin
                        state <= GAP;
                        cnt   <= CW'(T_GAP - 1);
                    end
                end
                GAP: begin
                    if (cnt == '0) state <= NIB_LO;
                    else cnt <= cnt - CW'(1);
                end
                NIB_LO: begin
                    if (tx_done) begin
                        state <= WAIT;
                        cnt   <= is_clr(rs_q, data_q) ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
`ifdef LCD_INIT_SEQ_EN
                    end else if (INIT_DONE || idx == 3'd0) begin
                        state     <= IDLE;
                        REQ_READY <= 1'b1;
                        INIT_DONE <= 1'b1;
                    end else begin
                        state <= idx[2] ? INIT_CMD : INIT_NIB;
                    end
`else
                    end else begin
                        state     <= IDLE;
                        REQ_READY <= 1'b1;
                    end
`endif
                end
                default: state <= PWRUP;
            endcase
        end
    end

    lcd_nibble_tx #(
        .T_SU (T_SU),
        .T_E  (T_E)
    ) u_tx (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .start  (tx_start),
        .nib    (tx_nib),
        .rs     (tx_rs),
        .db     (db),
        .lcd_rs (LCD_RS),
        .lcd_e  (LCD_E),
        .done   (tx_done)
    );

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed, table-driven check of lcd_ctrl byte writes, waits, handshake and reset.
module tb_lcd_ctrl;

    localparam int T_PWRUP = 100;
    localparam int T_SU    = 2;
    localparam int T_E     = 4;
    localparam int T_GAP   = 5;
    localparam int T_CMD   = 20;
    localparam int T_CLR   = 50;
    localparam int T_INIT  = 30;

    logic CLK = 1'b0;
    logic RST_N;
    logic REQ_VALID;
    logic REQ_RS;
    logic [7:0] REQ_DATA;
    logic REQ_READY, INIT_DONE, LCD_E, LCD_RS, LCD_RW, SF_E, SF_D, SF_C, SF_B, SF_A;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [3:0] hi;
        logic [3:0] lo;
        int         w;
    } vec_t;

    vec_t vt[8];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic pe = 1'b0;
    logic [4:0] nib_q[$];
    int rise_q[$];

    lcd_ctrl #(
        .T_PWRUP(T_PWRUP), .T_SU(T_SU), .T_E(T_E), .T_GAP(T_GAP), .T_CMD(T_CMD), .T_CLR(T_CLR),
        .T_INIT_W0(T_INIT), .T_INIT_W1(T_INIT), .T_INIT_W2(T_INIT), .T_INIT_W3(T_INIT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_RS(REQ_RS), .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY), .INIT_DONE(INIT_DONE), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .SF_E(SF_E), .SF_D(SF_D), .SF_C(SF_C), .SF_B(SF_B), .SF_A(SF_A)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every strobe: {RS, DB7..DB4} and the edge on which LCD_E rose.
    always @(negedge CLK) begin
        if (LCD_E && !pe) begin
            nib_q.push_back({LCD_RS, SF_D, SF_C, SF_B, SF_A});
            rise_q.push_back(cyc);
        end
        pe <= LCD_E;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int s);
        return s == 0 ? LCD_E : s == 1 ? REQ_READY : INIT_DONE;
    endfunction

    // Sample on falling edges until the chosen signal reaches v; a timeout is a failed check.
    task automatic wait_sig(input int s, input logic v, input int budget, input string nm, output int c);
        int n = 0;
        while (sig(s) !== v && n < budget) begin
            @(negedge CLK);
            n++;
        end
        c = cyc;
        chk(nm, {31'd0, sig(s)}, {31'd0, v});
    endtask

    function automatic logic [4:0] pins();
        return {LCD_RS, SF_D, SF_C, SF_B, SF_A};
    endfunction

    task automatic send_check(input vec_t v);
        int c, acc, r1, f1, r2, f2, rd;
        wait_sig(1, 1'b1, 500, "ready_before", c);
        REQ_VALID = 1'b1;
        REQ_RS    = v.rs;
        REQ_DATA  = v.d;
        @(negedge CLK);
        acc = cyc;
        REQ_VALID = 1'b0;
        REQ_RS    = ~v.rs;
        REQ_DATA  = ~v.d;
        chk("hi_pins", {27'd0, pins()}, {27'd0, v.rs, v.hi});
        chk("ready_drop", {31'd0, REQ_READY}, 32'd0);
        wait_sig(0, 1'b1, 100, "hi_rise", r1);
        chk("setup", r1 - acc, T_SU);
        chk("hi_pins_e", {27'd0, pins()}, {27'd0, v.rs, v.hi});
        wait_sig(0, 1'b0, 100, "hi_fall", f1);
        chk("hi_width", f1 - r1, T_E);
        wait_sig(0, 1'b1, 100, "lo_rise", r2);
        chk("gap", r2 - f1, T_GAP + T_SU);
        chk("lo_pins", {27'd0, pins()}, {27'd0, v.rs, v.lo});
        wait_sig(0, 1'b0, 100, "lo_fall", f2);
        chk("lo_width", f2 - r2, T_E);
        wait_sig(1, 1'b1, 500, "ready_back", rd);
        chk("post_wait", rd - f2, v.w);
    endtask

    task automatic after_release(input int c0);
        int c;
`ifdef LCD_INIT_SEQ_EN
        logic [4:0] exp_q[12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                  5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
        nib_q.delete();
        rise_q.delete();
        wait_sig(2, 1'b1, 5000, "init_done", c);
        chk("init_ready", {31'd0, REQ_READY}, 32'd1);
        chk("init_nib_count", nib_q.size(), 12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("init_nib%0d", i), {27'd0, i < nib_q.size() ? nib_q[i] : 5'h1F}, {27'd0, exp_q[i]});
        chk("pwrup_delay", rise_q.size() > 0 ? rise_q[0] - c0 : 0, T_PWRUP + T_SU);
`else
        @(negedge CLK);
        c = cyc - c0;
        chk("ready_first", {31'd0, REQ_READY}, 32'd1);
        chk("done_first", {31'd0, INIT_DONE}, 32'd1);
        chk("first_cycle", c, 1);
`endif
    endtask

    initial begin
        int c, c0;
        RST_N     = 1'b0;
        REQ_VALID = 1'b0;
        REQ_RS    = 1'b0;
        REQ_DATA  = 8'h00;
        vt[0] = '{1'b1, 8'h45, 4'h4, 4'h5, T_CMD};
        vt[1] = '{1'b0, 8'h01, 4'h0, 4'h1, T_CLR};
        vt[2] = '{1'b0, 8'h0C, 4'h0, 4'hC, T_CMD};
        vt[3] = '{1'b0, 8'h02, 4'h0, 4'h2, T_CLR};
        vt[4] = '{1'b0, 8'h03, 4'h0, 4'h3, T_CLR};
        vt[5] = '{1'b0, 8'h04, 4'h0, 4'h4, T_CMD};
        vt[6] = '{1'b1, 8'h00, 4'h0, 4'h0, T_CMD};
        vt[7] = '{1'b1, 8'hFF, 4'hF, 4'hF, T_CMD};

        repeat (3) @(negedge CLK);
        chk("rst_e", {31'd0, LCD_E}, 32'd0);
        chk("rst_ready", {31'd0, REQ_READY}, 32'd0);
        chk("rst_done", {31'd0, INIT_DONE}, 32'd0);
        chk("rst_sf_e", {31'd0, SF_E}, 32'd1);
        chk("rst_rw", {31'd0, LCD_RW}, 32'd0);
        chk("rst_pins", {27'd0, pins()}, 32'd0);
        RST_N = 1'b1;
        c0 = cyc;
        after_release(c0);

        for (int i = 0; i < 8; i++) send_check(vt[i]);

        // Back-to-back: REQ_VALID stays high; the second byte waits for the next REQ_READY.
        wait_sig(1, 1'b1, 500, "b2b_ready", c);
        nib_q.delete();
        REQ_VALID = 1'b1;
        REQ_RS    = 1'b1;
        REQ_DATA  = 8'h41;
        @(negedge CLK);
        chk("b2b_drop", {31'd0, REQ_READY}, 32'd0);
        REQ_DATA = 8'h5A;
        wait_sig(1, 1'b1, 500, "b2b_ready2", c);
        chk("b2b_first_nibs", nib_q.size(), 2);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("b2b_drop2", {31'd0, REQ_READY}, 32'd0);
        chk("b2b_hi2", {27'd0, pins()}, 32'h15);
        wait_sig(1, 1'b1, 500, "b2b_ready3", c);
        chk("b2b_nib_count", nib_q.size(), 4);
        chk("b2b_n0", {27'd0, nib_q.size() > 0 ? nib_q[0] : 5'h00}, 32'h14);
        chk("b2b_n1", {27'd0, nib_q.size() > 1 ? nib_q[1] : 5'h00}, 32'h11);
        chk("b2b_n2", {27'd0, nib_q.size() > 2 ? nib_q[2] : 5'h00}, 32'h15);
        chk("b2b_n3", {27'd0, nib_q.size() > 3 ? nib_q[3] : 5'h00}, 32'h1A);

        // Reset while LCD_E is high: strobe drops at once, then the full start-up repeats.
        REQ_VALID = 1'b1;
        REQ_RS    = 1'b1;
        REQ_DATA  = 8'h33;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        wait_sig(0, 1'b1, 100, "mid_rise", c);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_e", {31'd0, LCD_E}, 32'd0);
        chk("mid_ready", {31'd0, REQ_READY}, 32'd0);
        chk("mid_done", {31'd0, INIT_DONE}, 32'd0);
        chk("mid_sf_e", {31'd0, SF_E}, 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        c0 = cyc;
        after_release(c0);
        send_check(vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
